shooter_controller: RTL and testbench

Per-frame motion and facing controller for the player shooter sprite. It decodes the current keyboard keycode and advances a turn/move state machine once per video frame. It produces the registered ShooterX, ShooterY and ShooterDir values consumed by color_mapper. Position is clamped so the 32x32 sprite always lies entirely inside the blue floor region.

---
 rtl/game_pkg.sv | 50 +++++
 rtl/frame_tick_gen.sv | 28 ++
 rtl/shooter_controller.sv | 141 ++++++++++++++
 tb/tb_shooter_controller.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game types and constants: facing directions, keycodes, floor bounds
// and the shooter state encoding. Also used by color_mapper and future per-frame blocks.
package game_pkg;

   typedef enum logic [1:0] {
      UP    = 2'b00,
      RIGHT = 2'b01,
      DOWN  = 2'b10,
      LEFT  = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      TURN = 2'b01,
      MOVE = 2'b10
   } shooter_state_t;

   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_D = 8'h07;

   localparam int SPRITE_SIZE = 32;

   // Upper-left corner limits that keep the whole 32x32 sprite on the blue floor.
   localparam logic [9:0] FLOOR_X_MIN = 10'd32;
   localparam logic [9:0] FLOOR_X_MAX = 10'd576;
   localparam logic [9:0] FLOOR_Y_MIN = 10'd62;
   localparam logic [9:0] FLOOR_Y_MAX = 10'd416;

   typedef struct packed {
      logic valid;
      dir_t dir;
   } key_dec_t;

   function automatic key_dec_t decode_key(input logic [7:0] keycode);
      key_dec_t k;
      k.valid = 1'b1;
      k.dir   = UP;
      case (keycode)
         KEY_W:   k.dir = UP;
         KEY_D:   k.dir = RIGHT;
         KEY_S:   k.dir = DOWN;
         KEY_A:   k.dir = LEFT;
         default: k.valid = 1'b0;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the VGA frame strobe into the Clk domain and emits a one-Clk pulse
// on each rising edge. Flops reset high so a strobe already high at release never ticks.
module frame_tick_gen (
   input  logic clk,
   input  logic reset,
   input  logic frame_clk,
   output logic frame_tick
);

   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         prev  <= 1'b1;
      end else begin
         sync1 <= frame_clk;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign frame_tick = sync2 & ~prev;

endmodule

// File: rtl/shooter_controller.sv
// Per-frame turn/move controller for the player shooter sprite with floor clamping.
// Build option: SHOOTER_TURN_DELAY_EN adds the TURN state and its frame countdown.
module shooter_controller
   import game_pkg::*;
#(
   parameter int STEP        = 2,
   parameter int TURN_FRAMES = 4,
   parameter int X_INIT      = 304,
   parameter int Y_INIT      = 239
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   output logic [9:0] ShooterX,
   output logic [9:0] ShooterY,
   output logic [1:0] ShooterDir,
   output logic       ShooterMoving
);

   if (TURN_FRAMES < 1) begin : g_bad_turn_frames
      $error("TURN_FRAMES must be at least 1");
   end

   logic           frame_tick;
   shooter_state_t state, state_n;
   dir_t           dir, dir_n;
   logic [9:0]     x, x_n;
   logic [9:0]     y, y_n;
   logic           do_step;
   key_dec_t       key;

`ifdef SHOOTER_TURN_DELAY_EN
   localparam int CNT_W = (TURN_FRAMES > 1) ? $clog2(TURN_FRAMES) : 1;
   logic [CNT_W-1:0] turn_cnt, cnt_n;
`endif

   frame_tick_gen u_frame_tick (
      .clk        (Clk),
      .reset      (Reset),
      .frame_clk  (frame_clk),
      .frame_tick (frame_tick)
   );

   function automatic logic [9:0] step_up(input logic [9:0] pos, input logic [9:0] bound);
      logic [10:0] sum;
      sum = {1'b0, pos} + 11'(STEP);
      return (sum > {1'b0, bound}) ? bound : sum[9:0];
   endfunction

   function automatic logic [9:0] step_down(input logic [9:0] pos, input logic [9:0] bound);
      return ({1'b0, pos} < ({1'b0, bound} + 11'(STEP))) ? bound : (pos - 10'(STEP));
   endfunction

   always_comb begin
      state_n = state;
      dir_n   = dir;
      x_n     = x;
      y_n     = y;
      do_step = 1'b0;
      key     = decode_key(keycode);
`ifdef SHOOTER_TURN_DELAY_EN
      cnt_n   = turn_cnt;
`endif
      if (frame_tick) begin
         case (state)
            TURN: begin
`ifdef SHOOTER_TURN_DELAY_EN
               // The last countdown frame already enters MOVE, so the first step
               // lands on the frame after TURN_FRAMES held frames.
               if (!key.valid) begin
                  state_n = IDLE;
               end else if (key.dir != dir) begin
                  dir_n = key.dir;
                  cnt_n = CNT_W'(TURN_FRAMES - 1);
               end else if (turn_cnt <= CNT_W'(1)) begin
                  state_n = MOVE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = turn_cnt - CNT_W'(1);
               end
`else
               state_n = IDLE;
`endif
            end
            default: begin
               if (!key.valid) begin
                  state_n = IDLE;
               end else if (key.dir == dir) begin
                  state_n = MOVE;
                  do_step = 1'b1;
               end else begin
                  dir_n = key.dir;
`ifdef SHOOTER_TURN_DELAY_EN
                  state_n = TURN;
                  cnt_n   = CNT_W'(TURN_FRAMES - 1);
`else
                  state_n = MOVE;
                  do_step = 1'b1;
`endif
               end
            end
         endcase
         if (do_step) begin
            case (dir_n)
               UP:    y_n = step_down(y, FLOOR_Y_MIN);
               RIGHT: x_n = step_up(x, FLOOR_X_MAX);
               DOWN:  y_n = step_up(y, FLOOR_Y_MAX);
               LEFT:  x_n = step_down(x, FLOOR_X_MIN);
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         dir   <= UP;
         x     <= 10'(X_INIT);
         y     <= 10'(Y_INIT);
`ifdef SHOOTER_TURN_DELAY_EN
         turn_cnt <= '0;
`endif
      end else begin
         state <= state_n;
         dir   <= dir_n;
         x     <= x_n;
         y     <= y_n;
`ifdef SHOOTER_TURN_DELAY_EN
         turn_cnt <= cnt_n;
`endif
      end
   end

   assign ShooterX      = x;
   assign ShooterY      = y;
   assign ShooterDir    = dir;
   assign ShooterMoving = (state == MOVE);

endmodule

// File: tb/tb_shooter_controller.sv
// Bench for shooter_controller: directed table, wall/reset sequences and random
// key streams checked against a frame-level model of the movement rules.
module tb_shooter_controller;

   localparam int STEP        = 2;
   localparam int TURN_FRAMES = 4;
   localparam int XMIN = 32, XMAX = 576, YMIN = 62, YMAX = 416;
   localparam logic [7:0] K_W = 8'h1A, K_D = 8'h07, K_S = 8'h16, K_A = 8'h04;

   logic       clk;
   logic       Reset;
   logic       frame_clk;
   logic [7:0] keycode;
   logic [7:0] key2;
   logic [9:0] sx, sy, ox, oy;
   logic [1:0] sdir, odir;
   logic       smov, omov;

   int errors = 0;
   int checks = 0;
   int tick_cnt = 0;
   int frames_run = 0;

   // model state
   int m_x, m_y, m_dir, m_turn_age;
   bit m_moving;

   typedef struct {
      logic [7:0] key;
      int x;
      int y;
      int dir;
      int moving;
   } vec_t;
   vec_t tbl[8];

   shooter_controller #(.STEP(STEP), .TURN_FRAMES(TURN_FRAMES), .X_INIT(304), .Y_INIT(239)) u_dut (
      .Clk(clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
      .ShooterX(sx), .ShooterY(sy), .ShooterDir(sdir), .ShooterMoving(smov)
   );

   shooter_controller #(.STEP(STEP), .TURN_FRAMES(TURN_FRAMES), .X_INIT(33), .Y_INIT(415)) u_odd (
      .Clk(clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(key2),
      .ShooterX(ox), .ShooterY(oy), .ShooterDir(odir), .ShooterMoving(omov)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (u_dut.frame_tick === 1'b1) tick_cnt++;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int key_dir(input logic [7:0] k);
      case (k)
         8'h1A:   return 0;
         8'h07:   return 1;
         8'h16:   return 2;
         8'h04:   return 3;
         default: return -1;
      endcase
   endfunction

   task automatic model_reset();
      m_x = 304; m_y = 239; m_dir = 0; m_moving = 0; m_turn_age = 0;
   endtask

   task automatic model_step();
      case (m_dir)
         0: m_y = (m_y - STEP < YMIN) ? YMIN : m_y - STEP;
         1: m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP;
         2: m_y = (m_y + STEP > YMAX) ? YMAX : m_y + STEP;
         default: m_x = (m_x - STEP < XMIN) ? XMIN : m_x - STEP;
      endcase
   endtask

   // One frame of the movement rules; m_turn_age counts frames spent turning (0 = not turning).
   task automatic model_tick(input logic [7:0] k);
      int d;
      d = key_dir(k);
      if (d < 0) begin
         m_moving = 0;
         m_turn_age = 0;
      end else if (m_turn_age > 0) begin
         if (d != m_dir) begin
            m_dir = d;
            m_turn_age = 1;
         end else begin
            m_turn_age++;
            if (m_turn_age >= TURN_FRAMES) begin
               m_turn_age = 0;
               m_moving = 1;
            end
         end
      end else if (d == m_dir) begin
         m_moving = 1;
         model_step();
      end else begin
         m_dir = d;
`ifdef SHOOTER_TURN_DELAY_EN
         m_moving = 0;
         m_turn_age = 1;
`else
         m_moving = 1;
         model_step();
`endif
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_x"}, int'(sx), m_x);
      check({tag, "_y"}, int'(sy), m_y);
      check({tag, "_dir"}, int'(sdir), m_dir);
      check({tag, "_moving"}, int'(smov), int'(m_moving));
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      repeat (2) @(negedge clk);
      Reset = 1'b0;
      @(negedge clk);
      model_reset();
   endtask

   // Frame: strobe high 4 cycles (tick consumed inside), then junk key while low.
   task automatic frame(input logic [7:0] key, input logic [7:0] junk);
      keycode = key;
      frame_clk = 1'b1;
      repeat (4) @(negedge clk);
      keycode = junk;
      frame_clk = 1'b0;
      repeat (4) @(negedge clk);
      frames_run++;
   endtask

   task automatic frame_model(input logic [7:0] key, input string tag);
      frame(key, 8'($urandom_range(0, 255)));
      model_tick(key);
      check_model(tag);
   endtask

   initial begin
      Reset = 1'b1;
      frame_clk = 1'b0;
      keycode = 8'h00;
      key2 = 8'h00;
      do_reset();

      check("rst_x", int'(sx), 304);
      check("rst_y", int'(sy), 239);
      check("rst_dir", int'(sdir), 0);
      check("rst_moving", int'(smov), 0);

      tbl[0] = '{8'h00, 304, 239, 0, 0};
      tbl[1] = '{8'h00, 304, 239, 0, 0};
      tbl[2] = '{8'h00, 304, 239, 0, 0};
      tbl[3] = '{K_W, 304, 237, 0, 1};
      tbl[4] = '{K_W, 304, 235, 0, 1};
      tbl[5] = '{K_W, 304, 233, 0, 1};
      tbl[6] = '{8'h00, 304, 233, 0, 0};
      tbl[7] = '{K_W, 304, 231, 0, 1};
      for (int i = 0; i < 8; i++) begin
         frame(tbl[i].key, 8'($urandom_range(0, 255)));
         model_tick(tbl[i].key);
         check($sformatf("tbl%0d_x", i), int'(sx), tbl[i].x);
         check($sformatf("tbl%0d_y", i), int'(sy), tbl[i].y);
         check($sformatf("tbl%0d_dir", i), int'(sdir), tbl[i].dir);
         check($sformatf("tbl%0d_moving", i), int'(smov), tbl[i].moving);
      end
      check("tick_count_tbl", tick_cnt, 8);

`ifdef SHOOTER_TURN_DELAY_EN
      for (int i = 1; i <= 5; i++) begin
         frame(K_D, 8'h00);
         model_tick(K_D);
         check($sformatf("turn%0d_dir", i), int'(sdir), 1);
         check($sformatf("turn%0d_x", i), int'(sx), (i == 5) ? 306 : 304);
         check($sformatf("turn%0d_moving", i), int'(smov), (i == 4 || i == 5) ? 1 : 0);
      end
      frame(8'h00, K_D);
      model_tick(8'h00);
      check("release_x", int'(sx), 306);
      check("release_moving", int'(smov), 0);
`endif

      do_reset();
      frame(K_S, 8'h00);
      model_tick(K_S);
      check("s_dir", int'(sdir), 2);
`ifdef SHOOTER_TURN_DELAY_EN
      check("s_y", int'(sy), 239);
      check("s_moving", int'(smov), 0);
`else
      check("s_y", int'(sy), 241);
      check("s_moving", int'(smov), 1);
`endif

      // Walk right to X=400, then reset mid-move with the strobe high at release.
      do_reset();
      for (int i = 0; i < 300 && m_x < 400; i++) frame_model(K_D, "walk400");
      check("pre_rst_x", int'(sx), 400);
      check("pre_rst_moving", int'(smov), 1);
      keycode = K_D;
      frame_clk = 1'b1;
      Reset = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
      keycode = K_W;
      check("midrst_x", int'(sx), 304);
      check("midrst_moving", int'(smov), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("no_false_tick_y", int'(sy), 239);
      end
      frame_clk = 1'b0;
      repeat (4) @(negedge clk);
      model_reset();
      frame_model(K_W, "after_rst");
      check("after_rst_y", int'(sy), 237);

      // Right wall, then left wall.
      for (int i = 0; i < 400 && m_x < XMAX; i++) frame_model(K_D, "walk_right");
      for (int i = 0; i < 3; i++) begin
         frame_model(K_D, "right_wall");
         check("right_wall_x", int'(sx), 576);
         check("right_wall_moving", int'(smov), 1);
      end
      for (int i = 0; i < 400 && m_x > XMIN; i++) frame_model(K_A, "walk_left");
      for (int i = 0; i < 2; i++) begin
         frame_model(K_A, "left_wall");
         check("left_wall_x", int'(sx), 32);
      end

      // Odd start positions: the final step clamps short of a full STEP.
      keycode = 8'h00;
      key2 = K_A;
      for (int i = 0; i < 8; i++) begin
         frame(8'h00, 8'h00);
         model_tick(8'h00);
      end
      check("odd_left_x", int'(ox), 32);
      check("odd_left_moving", int'(omov), 1);
      key2 = K_S;
      for (int i = 0; i < 8; i++) begin
         frame(8'h00, 8'h00);
         model_tick(8'h00);
      end
      check("odd_down_y", int'(oy), 416);
      check("odd_down_x", int'(ox), 32);
      check("odd_down_dir", int'(odir), 2);
      key2 = 8'h00;

      // Random key runs, with junk keys between ticks.
      begin
         logic [7:0] k;
         int run;
         k = 8'h00;
         run = 0;
         for (int f = 0; f < 120; f++) begin
            if (run == 0) begin
               case ($urandom_range(0, 5))
                  0: k = 8'h00;
                  1: k = K_W;
                  2: k = K_A;
                  3: k = K_S;
                  4: k = K_D;
                  default: k = 8'($urandom_range(0, 255));
               endcase
               run = $urandom_range(1, 7);
            end
            run--;
            frame_model(k, $sformatf("rand%0d", f));
         end
      end

      check("tick_count_total", tick_cnt, frames_run);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
